ram_port_arbiter: RTL and testbench

- Round-robin arbiter and transfer sequencer for the single shared RAM port. Requesters are the instruction and data paths of both CPUs.
- Sits between the per-CPU cache request lines and the RAM interface, below the coherence controller.
- Grants one requester at a time and sequences one- or two-word (block) transfers.
- Enforces fairness with per-requester age counters that escalate starved requesters to urgent priority.

---
 rtl/ram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared RAM port.
// Age counters escalate starved requesters to urgent priority for IDLE selection.
module ram_port_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned AGE_MAX = 15
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    wen,
   input  logic [NREQ-1:0]    burst,
   input  logic [NREQ*32-1:0] addr,
   input  logic [NREQ*32-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [31:0]        rdata,
   output logic               busy,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [31:0]        ramaddr,
   output logic [31:0]        ramstore,
   input  logic [31:0]        ramload,
   input  logic [1:0]         ramstate
);

   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned AgeW = $clog2(AGE_MAX + 1);
   localparam logic [1:0] RamAccess = 2'd2;

   typedef enum logic [1:0] {StIdle, StXfer1, StXfer2} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [IdxW-1:0]   last_q, last_d;
   logic [IdxW-1:0]   win;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [AgeW-1:0]   age_q [NREQ];
   logic [AgeW-1:0]   age_d [NREQ];
   logic [31:0]       addr_a [NREQ];
   logic [31:0]       wdata_a [NREQ];
   logic              own_req, own_wen, own_burst;
   logic [31:0]       own_addr, own_wdata;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         addr_a[i]  = addr[32*i +: 32];
         wdata_a[i] = wdata[32*i +: 32];
      end
   end

   assign own_req   = req[owner_q];
   assign own_wen   = wen[owner_q];
   assign own_burst = burst[owner_q];
   assign own_addr  = addr_a[owner_q];
   assign own_wdata = wdata_a[owner_q];

   // Urgent requesters (lowest index first) beat the round-robin scan from last+1.
   always_comb begin
      logic found;
      int   idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && req[i] && (age_q[i] == AgeW'(AGE_MAX))) begin
            win   = IdxW'(i);
            found = 1'b1;
         end
      end
      for (int k = 1; k <= int'(NREQ); k++) begin
         idx = (int'(last_q) + k) % int'(NREQ);
         if (!found && req[idx]) begin
            win   = IdxW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      done     = '0;
      rdata    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state_q)
         StIdle: begin
            if (|req) begin
               owner_d = win;
               gnt_d   = NREQ'(1) << win;
               state_d = StXfer1;
            end
         end
         StXfer1, StXfer2: begin
            if (!own_req) begin
               state_d = StIdle;
               gnt_d   = '0;
               last_d  = owner_q;
            end else begin
               ramREN   = ~own_wen;
               ramWEN   = own_wen;
               ramaddr  = (own_addr & ~32'h3) + ((state_q == StXfer2) ? 32'd4 : 32'd0);
               ramstore = own_wdata;
               if (ramstate == RamAccess) begin
                  done  = gnt_q;
                  rdata = own_wen ? 32'h0 : ramload;
                  if ((state_q == StXfer1) && own_burst) begin
                     state_d = StXfer2;
                  end else begin
                     state_d = StIdle;
                     gnt_d   = '0;
                     last_d  = owner_q;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // The owner (or the requester about to become owner) holds age zero.
   always_comb begin
      logic is_owner;
      for (int i = 0; i < int'(NREQ); i++) begin
         is_owner = (state_q == StIdle) ? ((|req) && (win == IdxW'(i)))
                                        : (owner_q == IdxW'(i));
         if (!req[i] || is_owner) begin
            age_d[i] = '0;
         end else if (age_q[i] != AgeW'(AGE_MAX)) begin
            age_d[i] = age_q[i] + AgeW'(1);
         end else begin
            age_d[i] = age_q[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= IdxW'(NREQ - 1);
         gnt_q   <= '0;
         for (int i = 0; i < int'(NREQ); i++) begin
            age_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         for (int i = 0; i < int'(NREQ); i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reset, single read, round robin, burst write,
// error retry, abort, reset mid-transfer and starvation escalation.
module tb_ram_port_arbiter;

   logic         CLK = 1'b0;
   logic         nRST;
   logic [3:0]   req, wen, burst;
   logic [127:0] addr, wdata;
   logic [3:0]   gnt, done;
   logic [31:0]  rdata, ramaddr, ramstore, ramload;
   logic         busy, ramREN, ramWEN;
   logic [1:0]   ramstate;
   logic [31:0]  a_arr [4];
   logic [31:0]  w_arr [4];
   logic [3:0]   exp_g [4];
   logic [31:0]  exp_a [4];
   int           total = 0;
   int           bad = 0;

   assign addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign wdata = {w_arr[3], w_arr[2], w_arr[1], w_arr[0]};

   always #5 CLK = ~CLK;

   ram_port_arbiter #(.NREQ(4), .AGE_MAX(15)) dut (
      .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .burst(burst), .addr(addr),
      .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   initial begin
      req = '0; wen = '0; burst = '0; ramload = '0; ramstate = 2'd0;
      for (int i = 0; i < 4; i++) begin
         a_arr[i] = '0;
         w_arr[i] = '0;
      end
      nRST = 1'b1;
      #1 nRST = 1'b0;
      settle();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ren", 32'(ramREN), 0);
      chk("rst_wen", 32'(ramWEN), 0);
      chk("rst_addr", ramaddr, 0);
      chk("rst_store", ramstore, 0);
      chk("rst_rdata", rdata, 0);
      @(negedge CLK);
      nRST = 1'b1;

      // Single read from requester 1
      req = 4'b0010; a_arr[1] = 32'h104; ramstate = 2'd2; ramload = 32'hDEADBEEF;
      settle();
      chk("rd_idle_gnt", 32'(gnt), 0);
      chk("rd_idle_ren", 32'(ramREN), 0);
      tick(); settle();
      chk("rd_gnt", 32'(gnt), 32'h2);
      chk("rd_ren", 32'(ramREN), 1);
      chk("rd_wen", 32'(ramWEN), 0);
      chk("rd_addr", ramaddr, 32'h104);
      chk("rd_done", 32'(done), 32'h2);
      chk("rd_rdata", rdata, 32'hDEADBEEF);
      chk("rd_busy", 32'(busy), 1);
      tick(); req = '0; settle();
      chk("rd_end_gnt", 32'(gnt), 0);
      chk("rd_end_done", 32'(done), 0);
      chk("rd_end_busy", 32'(busy), 0);

      // Round robin between 0 and 2, fresh out of reset
      nRST = 1'b0; #1 nRST = 1'b1;
      req = 4'b0101; a_arr[0] = 32'h13; a_arr[2] = 32'h300;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
      exp_a[0] = 32'h10;  exp_a[1] = 32'h300; exp_a[2] = 32'h10;  exp_a[3] = 32'h300;
      settle();
      for (int g = 0; g < 4; g++) begin
         chk("rr_idle_gnt", 32'(gnt), 0);
         tick(); settle();
         chk("rr_gnt", 32'(gnt), 32'(exp_g[g]));
         chk("rr_done", 32'(done), 32'(exp_g[g]));
         chk("rr_addr", ramaddr, exp_a[g]);
         tick(); settle();
      end
      req = '0;

      // Burst write from requester 3
      req = 4'b1000; wen = 4'b1000; burst = 4'b1000; a_arr[3] = 32'h200; w_arr[3] = 32'h11;
      settle();
      chk("bw_idle_busy", 32'(busy), 0);
      tick(); settle();
      chk("bw1_gnt", 32'(gnt), 32'h8);
      chk("bw1_busy", 32'(busy), 1);
      chk("bw1_wen", 32'(ramWEN), 1);
      chk("bw1_ren", 32'(ramREN), 0);
      chk("bw1_addr", ramaddr, 32'h200);
      chk("bw1_store", ramstore, 32'h11);
      chk("bw1_done", 32'(done), 32'h8);
      chk("bw1_rdata", rdata, 0);
      tick(); w_arr[3] = 32'h22; settle();
      chk("bw2_busy", 32'(busy), 1);
      chk("bw2_gnt", 32'(gnt), 32'h8);
      chk("bw2_wen", 32'(ramWEN), 1);
      chk("bw2_addr", ramaddr, 32'h204);
      chk("bw2_store", ramstore, 32'h22);
      chk("bw2_done", 32'(done), 32'h8);
      tick(); req = '0; wen = '0; burst = '0; settle();
      chk("bw_end_busy", 32'(busy), 0);
      chk("bw_end_gnt", 32'(gnt), 0);

      // Error retry: three ERROR cycles then ACCESS
      req = 4'b0010; ramstate = 2'd3; ramload = 32'hCAFEF00D;
      settle();
      tick(); settle();
      for (int c = 0; c < 3; c++) begin
         chk("err_gnt", 32'(gnt), 32'h2);
         chk("err_ren", 32'(ramREN), 1);
         chk("err_addr", ramaddr, 32'h104);
         chk("err_done", 32'(done), 0);
         tick(); settle();
      end
      ramstate = 2'd2; settle();
      chk("err_ok_ren", 32'(ramREN), 1);
      chk("err_ok_addr", ramaddr, 32'h104);
      chk("err_ok_done", 32'(done), 32'h2);
      chk("err_ok_rdata", rdata, 32'hCAFEF00D);
      tick(); req = '0; settle();
      chk("err_end_done", 32'(done), 0);
      chk("err_end_gnt", 32'(gnt), 0);

      // Abort in XFER2, with address wrap on the second word
      req = 4'b0100; burst = 4'b0100; a_arr[2] = 32'hFFFFFFFC; ramload = 32'h55555555;
      settle();
      tick(); settle();
      chk("ab1_gnt", 32'(gnt), 32'h4);
      chk("ab1_done", 32'(done), 32'h4);
      chk("ab1_addr", ramaddr, 32'hFFFFFFFC);
      chk("ab1_rdata", rdata, 32'h55555555);
      tick(); ramstate = 2'd1; settle();
      chk("ab2_wrap_addr", ramaddr, 32'h0);
      chk("ab2_done", 32'(done), 0);
      chk("ab2_ren", 32'(ramREN), 1);
      req = '0; ramstate = 2'd2; settle();
      chk("ab_drop_done", 32'(done), 0);
      chk("ab_drop_ren", 32'(ramREN), 0);
      chk("ab_drop_wen", 32'(ramWEN), 0);
      tick(); burst = '0; settle();
      chk("ab_idle_busy", 32'(busy), 0);
      chk("ab_idle_gnt", 32'(gnt), 0);

      // Reset while requester 3 is in XFER1
      req = 4'b1000; ramstate = 2'd1; settle();
      tick(); settle();
      chk("rx_gnt", 32'(gnt), 32'h8);
      chk("rx_ren", 32'(ramREN), 1);
      nRST = 1'b0; settle();
      chk("rx_rst_gnt", 32'(gnt), 0);
      chk("rx_rst_busy", 32'(busy), 0);
      chk("rx_rst_ren", 32'(ramREN), 0);
      chk("rx_rst_addr", ramaddr, 0);
      chk("rx_rst_done", 32'(done), 0);
      req = 4'b1001; nRST = 1'b1; settle();
      tick(); settle();
      chk("rx_next_gnt", 32'(gnt), 32'h1);
      ramstate = 2'd2; settle();
      chk("rx_next_done", 32'(done), 32'h1);
      tick(); req = '0; settle();

      // Starvation: all four request, long BUSY transfers saturate the waiting ages
      nRST = 1'b0; #1;
      req = 4'b1111; ramstate = 2'd1; nRST = 1'b1;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001;
      settle();
      for (int t = 0; t < 3; t++) begin
         tick(); settle();
         chk("sv_gnt", 32'(gnt), 32'(exp_g[t]));
         repeat (19) tick();
         settle();
         chk("sv_hold_done", 32'(done), 0);
         ramstate = 2'd2; settle();
         chk("sv_done", 32'(done), 32'(exp_g[t]));
         tick(); ramstate = 2'd1; settle();
         chk("sv_bubble_gnt", 32'(gnt), 0);
      end
      req = '0;
      tick(); settle();
      chk("sv_end_busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
